// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite to SRAM-bridge slave.
// Used by axi_lite_sram_slave and its optional lfsr_delay sub-block.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_RESP = 2'd2,
    ST_WR_RESP = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  // 33-bit compare so a window ending at 4 GiB cannot wrap to zero.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] w_a;
    logic [32:0] w_lo;
    logic [32:0] w_hi;
    w_a  = {1'b0, addr};
    w_lo = {1'b0, base};
    w_hi = w_lo + {1'b0, size};
    return (w_a >= w_lo) && (w_a < w_hi);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_lite_sram_slave_lfsr_delay.sv
// Pseudo-random response delay: 4-bit LFSR (x^4+x^3+1, seed 4'b1001) that
// loads a down-counter on each accept; o_done is high when the count is zero.
module lfsr_delay (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  output logic o_done
);

  logic [3:0] r_lfsr;
  logic [3:0] r_count;
  logic       w_fb;

  assign w_fb = r_lfsr[3] ^ r_lfsr[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr  <= 4'b1001;
      r_count <= 4'd0;
    end else begin
      r_lfsr <= {r_lfsr[2:0], w_fb};
      if (i_load) begin
        r_count <= r_lfsr;
      end else if (r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite single-beat slave in front of the SRAM bridge (1-cycle registered read).
// Optional random response delay when AXI_LITE_SRAM_SLAVE_DELAY_EN is defined.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        sram_read,
  output logic [31:0] sram_r_addr,
  input  logic [31:0] sram_r_data,
  output logic        sram_write,
  output logic [31:0] sram_w_addr,
  output logic [31:0] sram_w_data,
  output logic [3:0]  sram_w_strb,
  output state_t      dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high. Readies are combinational and only raised in IDLE for the granted
  // side, so a grant is the handshake. rvalid/bvalid stay high with stable
  // payload until the matching ready is seen.

  state_t      r_state;
  state_t      w_next_state;
  grant_t      r_last_grant;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;
  logic        r_rd_ok;
  logic        r_rd_cap;

  logic w_idle;
  logic w_rd_req;
  logic w_wr_req;
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_rd_in;
  logic w_wr_in;
  logic w_delay_done;

  // Gating with reset keeps readies and strobes low while reset is held.
  assign w_idle     = (r_state == ST_IDLE) && reset;
  assign w_rd_req   = arvalid;
  assign w_wr_req   = awvalid && wvalid;
  assign w_grant_rd = w_idle && w_rd_req && (!w_wr_req || (r_last_grant == GRANT_WRITE));
  assign w_grant_wr = w_idle && w_wr_req && (!w_rd_req || (r_last_grant == GRANT_READ));
  assign w_rd_in    = in_window(araddr, MEM_BASE, MEM_SIZE);
  assign w_wr_in    = in_window(awaddr, MEM_BASE, MEM_SIZE);

`ifdef AXI_LITE_SRAM_SLAVE_DELAY_EN
  lfsr_delay u_delay (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_grant_rd || w_grant_wr),
    .o_done (w_delay_done)
  );
`else
  assign w_delay_done = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_rd) begin
          w_next_state = ST_RD_WAIT;
        end else if (w_grant_wr) begin
          w_next_state = ST_WR_RESP;
        end
      end
      ST_RD_WAIT: if (w_delay_done) w_next_state = ST_RD_RESP;
      ST_RD_RESP: if (rready) w_next_state = ST_IDLE;
      ST_WR_RESP: if (w_delay_done && bready) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    arready     = w_grant_rd;
    awready     = w_grant_wr;
    wready      = w_grant_wr;
    sram_read   = w_grant_rd && w_rd_in;
    sram_write  = w_grant_wr && w_wr_in;
    sram_r_addr = word_addr(araddr);
    sram_w_addr = word_addr(awaddr);
    sram_w_data = wdata;
    sram_w_strb = wstrb;
    rvalid      = (r_state == ST_RD_RESP);
    bvalid      = (r_state == ST_WR_RESP) && w_delay_done;
    rdata       = r_rdata;
    rresp       = r_rresp;
    bresp       = r_bresp;
    dbg_state   = r_state;
  end

  // Read data is captured exactly once, the cycle after the accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GRANT_WRITE;
      r_rdata      <= 32'd0;
      r_rresp      <= RESP_OKAY;
      r_bresp      <= RESP_OKAY;
      r_rd_ok      <= 1'b0;
      r_rd_cap     <= 1'b0;
    end else begin
      r_rd_cap <= w_grant_rd;
      if (w_grant_rd) begin
        r_last_grant <= GRANT_READ;
        r_rd_ok      <= w_rd_in;
      end else if (w_grant_wr) begin
        r_last_grant <= GRANT_WRITE;
        r_bresp      <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_rd_cap) begin
        r_rdata <= r_rd_ok ? sram_r_data : 32'd0;
        r_rresp <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: vector table of single transactions
// plus hand-written sequences for backpressure, arbitration, AW/W skew and reset.
module tb_axi_lite_sram_slave;
  import axi_lite_pkg::*;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0800_0000;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        sram_read;
  logic [31:0] sram_r_addr;
  logic [31:0] sram_r_data;
  logic        sram_write;
  logic [31:0] sram_w_addr;
  logic [31:0] sram_w_data;
  logic [3:0]  sram_w_strb;
  state_t      dbg_state;

  logic [31:0] bridge_val;
  int          rd_pulses;
  int          wr_pulses;
  int          both_cnt;
  int          n_checks;
  int          n_errors;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_saddr;
    logic        exp_strobe;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  axi_lite_sram_slave #(
    .MEM_BASE (MEM_BASE),
    .MEM_SIZE (MEM_SIZE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .sram_read   (sram_read),
    .sram_r_addr (sram_r_addr),
    .sram_r_data (sram_r_data),
    .sram_write  (sram_write),
    .sram_w_addr (sram_w_addr),
    .sram_w_data (sram_w_data),
    .sram_w_strb (sram_w_strb),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bridge model: registered read, garbage unless a read strobe was seen.
  always @(posedge clock) begin
    sram_r_data <= sram_read ? bridge_val : 32'hBAD0_BAD0;
  end

  always @(negedge clock) begin
    if (sram_read) rd_pulses <= rd_pulses + 1;
    if (sram_write) wr_pulses <= wr_pulses + 1;
    if (sram_read && sram_write) both_cnt <= both_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Driver: one read, rready held low for 'hold' cycles after rvalid.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] bval,
                          input logic [31:0] exp_saddr, input logic exp_strobe,
                          input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                          input int hold);
    int n;
    int lat;
    int base_rd;
    logic seen;
    logic [31:0] saddr;
    @(posedge clock); #1;
    araddr = addr; arvalid = 1'b1; bridge_val = bval; rready = (hold == 0);
    base_rd = rd_pulses;
    n = 0;
    @(negedge clock);
    while (!arready && n < 20) begin @(negedge clock); n++; end
    check("ar_accept", 32'(arready), 32'd1);
    seen = sram_read; saddr = sram_r_addr;
    @(posedge clock); #1;
    arvalid = 1'b0; araddr = 32'd0;
    lat = 1;
    @(negedge clock);
    while (!rvalid && lat < 40) begin @(negedge clock); lat++; end
    check("rd_latency", 32'(lat), 32'd2);
    check("rdata", rdata, exp_rdata);
    check("rresp", 32'(rresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_rdata);
    end
    if (hold != 0) begin
      @(posedge clock); #1 rready = 1'b1;
      @(negedge clock);
    end
    @(negedge clock);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("rd_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    #1;
    check("rd_strobe_at_accept", 32'(seen), 32'(exp_strobe));
    check("rd_pulse_count", 32'(rd_pulses - base_rd), exp_strobe ? 32'd1 : 32'd0);
    if (exp_strobe) check("sram_r_addr", saddr, exp_saddr);
  endtask

  // Driver: one write, bready held low for 'hold' cycles after bvalid.
  task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_saddr,
                           input logic exp_strobe, input logic [1:0] exp_resp,
                           input int hold);
    int n;
    int lat;
    int base_wr;
    logic seen;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [3:0] ss;
    @(posedge clock); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    bready = (hold == 0);
    base_wr = wr_pulses;
    n = 0;
    @(negedge clock);
    while (!(awready && wready) && n < 20) begin @(negedge clock); n++; end
    check("aw_w_accept", 32'(awready && wready), 32'd1);
    seen = sram_write; sa = sram_w_addr; sd = sram_w_data; ss = sram_w_strb;
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!bvalid && lat < 40) begin @(negedge clock); lat++; end
    check("wr_latency", 32'(lat), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bresp_hold", 32'(bresp), 32'(exp_resp));
    end
    if (hold != 0) begin
      @(posedge clock); #1 bready = 1'b1;
      @(negedge clock);
    end
    @(negedge clock);
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("wr_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    #1;
    check("wr_strobe_at_accept", 32'(seen), 32'(exp_strobe));
    check("wr_pulse_count", 32'(wr_pulses - base_wr), exp_strobe ? 32'd1 : 32'd0);
    if (exp_strobe) begin
      check("sram_w_addr", sa, exp_saddr);
      check("sram_w_data", sd, data);
      check("sram_w_strb", 32'(ss), 32'(strb));
    end
  endtask

  initial begin
    int g;
    int cyc;
    int both_rdy;
    int gcyc[4];
    bit gkind[4];

    n_checks = 0; n_errors = 0;
    rd_pulses = 0; wr_pulses = 0; both_cnt = 0;
    bridge_val = 32'd0;

    //            wr addr           data           strb  exp_saddr      stb resp         exp_rdata      hold
    vecs[0]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 32'h8000_0010, 1'b1, RESP_OKAY,   32'hDEAD_BEEF, 0};
    vecs[1]  = '{1'b0, 32'h8000_0013, 32'hCAFE_F00D, 4'h0, 32'h8000_0010, 1'b1, RESP_OKAY,   32'hCAFE_F00D, 3};
    vecs[2]  = '{1'b0, 32'h7FFF_FFFC, 32'h1111_1111, 4'h0, 32'h0000_0000, 1'b0, RESP_SLVERR, 32'h0000_0000, 0};
    vecs[3]  = '{1'b0, 32'h87FF_FFFC, 32'h0123_4567, 4'h0, 32'h87FF_FFFC, 1'b1, RESP_OKAY,   32'h0123_4567, 0};
    vecs[4]  = '{1'b0, 32'h8800_0000, 32'h2222_2222, 4'h0, 32'h0000_0000, 1'b0, RESP_SLVERR, 32'h0000_0000, 0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFC, 32'h3333_3333, 4'h0, 32'h0000_0000, 1'b0, RESP_SLVERR, 32'h0000_0000, 0};
    vecs[6]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 4'h3, 32'h8000_0004, 1'b1, RESP_OKAY,   32'h0000_0000, 5};
    vecs[7]  = '{1'b1, 32'h8800_0000, 32'h5555_AAAA, 4'hF, 32'h0000_0000, 1'b0, RESP_SLVERR, 32'h0000_0000, 0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0F0F_0F0F, 4'h0, 32'h8000_0000, 1'b1, RESP_OKAY,   32'h0000_0000, 0};
    vecs[9]  = '{1'b1, 32'h87FF_FFFF, 32'hA5A5_A5A5, 4'hF, 32'h87FF_FFFC, 1'b1, RESP_OKAY,   32'h0000_0000, 0};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h7777_7777, 4'h8, 32'h0000_0000, 1'b0, RESP_SLVERR, 32'h0000_0000, 0};

    // Reset with every request asserted: nothing may be granted or strobed.
    reset = 1'b0;
    idle_inputs();
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = MEM_BASE; awaddr = MEM_BASE;
    repeat (3) @(negedge clock);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_sram_read", 32'(sram_read), 32'd0);
    check("rst_sram_write", 32'(sram_write), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr)
        run_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_saddr,
                  vecs[i].exp_strobe, vecs[i].exp_resp, vecs[i].hold);
      else
        run_read(vecs[i].addr, vecs[i].data, vecs[i].exp_saddr, vecs[i].exp_strobe,
                 vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].hold);
    end

    // Round-robin: both sides requesting continuously right after reset.
    do_reset();
    @(posedge clock); #1;
    araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b1; bridge_val = 32'h600D_600D;
    awaddr = 32'h8000_0024; wdata = 32'h0BAD_CAFE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    g = 0; cyc = 0; both_rdy = 0;
    while (g < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (arready && awready) both_rdy++;
      if (arready) begin
        gkind[g] = 1'b0; gcyc[g] = cyc; g++;
      end else if (awready) begin
        gkind[g] = 1'b1; gcyc[g] = cyc; g++;
      end
    end
    @(posedge clock); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clock);
    check("arb_grant_count", 32'(g), 32'd4);
    check("arb_both_ready", 32'(both_rdy), 32'd0);
    if (g == 4) begin
      check("arb_grant0_read", 32'(gkind[0]), 32'd0);
      check("arb_grant1_write", 32'(gkind[1]), 32'd1);
      check("arb_grant2_read", 32'(gkind[2]), 32'd0);
      check("arb_grant3_write", 32'(gkind[3]), 32'd1);
      check("arb_rd_to_wr_gap", 32'(gcyc[1] - gcyc[0]), 32'd3);
      check("arb_wr_to_rd_gap", 32'(gcyc[2] - gcyc[1]), 32'd2);
      check("arb_rd_to_wr_gap2", 32'(gcyc[3] - gcyc[2]), 32'd3);
    end
    check("arb_idle_after", 32'(dbg_state), 32'(ST_IDLE));

    // AW without W for three cycles, then W arrives.
    @(posedge clock); #1;
    idle_inputs();
    awaddr = 32'h8000_0008; wdata = 32'h89AB_CDEF; wstrb = 4'hC; awvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("skew_awready_low", 32'(awready), 32'd0);
      check("skew_wready_low", 32'(wready), 32'd0);
    end
    @(posedge clock); #1 wvalid = 1'b1;
    @(negedge clock);
    check("skew_awready", 32'(awready), 32'd1);
    check("skew_wready", 32'(wready), 32'd1);
    check("skew_sram_write", 32'(sram_write), 32'd1);
    check("skew_w_addr", sram_w_addr, 32'h8000_0008);
    @(posedge clock); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clock);
    check("skew_bvalid", 32'(bvalid), 32'd1);
    @(negedge clock);
    check("skew_bvalid_drop", 32'(bvalid), 32'd0);

    // Reset while the read response is waiting for rready.
    @(posedge clock); #1;
    idle_inputs();
    araddr = 32'h8000_0040; arvalid = 1'b1; bridge_val = 32'h1357_9BDF;
    @(negedge clock);
    check("mid_ar_accept", 32'(arready), 32'd1);
    @(posedge clock); #1 arvalid = 1'b0;
    cyc = 0;
    @(negedge clock);
    while (!rvalid && cyc < 40) begin @(negedge clock); cyc++; end
    check("mid_rvalid_up", 32'(rvalid), 32'd1);
    check("mid_rdata", rdata, 32'h1357_9BDF);
    #2 reset = 1'b0;
    #1;
    check("mid_rvalid_async_drop", 32'(rvalid), 32'd0);
    check("mid_rdata_cleared", rdata, 32'd0);
    check("mid_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rvalid", 32'(rvalid), 32'd0);
    check("post_bvalid", 32'(bvalid), 32'd0);
    check("post_rresp", 32'(rresp), 32'd0);
    check("post_state", 32'(dbg_state), 32'(ST_IDLE));
    run_read(32'h8000_0044, 32'h2468_ACE0, 32'h8000_0044, 1'b1, RESP_OKAY, 32'h2468_ACE0, 0);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
